// File: rtl/blake_round_ctrl_pkg.sv
// Shared widths, BLAKE-512 constants, state-layout helpers and the round controller FSM encoding.
package blake512_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned H_WORDS = 8;
  localparam int unsigned S_WORDS = 4;
  localparam int unsigned V_WORDS = 16;
  localparam int unsigned H_W     = WORD_W * H_WORDS;
  localparam int unsigned S_W     = WORD_W * S_WORDS;
  localparam int unsigned T_W     = 2 * WORD_W;
  localparam int unsigned V_W     = WORD_W * V_WORDS;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t C0 = 64'h243F6A8885A308D3;
  localparam word_t C1 = 64'h13198A2E03707344;
  localparam word_t C2 = 64'hA4093822299F31D0;
  localparam word_t C3 = 64'h082EFA98EC4E6C89;
  localparam word_t C4 = 64'h452821E638D01377;
  localparam word_t C5 = 64'hBE5466CF34E90C6C;
  localparam word_t C6 = 64'hC0AC29B7C97C50DD;
  localparam word_t C7 = 64'h3F84D5B5B5470917;

  typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

  // Word 0 sits in the most significant slice of every packed state vector.
  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned n_words);
    return WORD_W * (n_words - 1 - idx);
  endfunction

  function automatic word_t h_word(input logic [H_W-1:0] h, input int unsigned idx);
    return h[word_lsb(idx, H_WORDS) +: WORD_W];
  endfunction

  function automatic word_t s_word(input logic [S_W-1:0] s, input int unsigned idx);
    return s[word_lsb(idx, S_WORDS) +: WORD_W];
  endfunction

  function automatic word_t v_word(input logic [V_W-1:0] v, input int unsigned idx);
    return v[word_lsb(idx, V_WORDS) +: WORD_W];
  endfunction

  function automatic logic [V_W-1:0] init_state(input logic [H_W-1:0] h,
                                                input logic [S_W-1:0] s,
                                                input logic [T_W-1:0] t);
    return {h, s ^ {C0, C1, C2, C3},
            t[T_W-1:WORD_W] ^ C4, t[T_W-1:WORD_W] ^ C5,
            t[WORD_W-1:0] ^ C6, t[WORD_W-1:0] ^ C7};
  endfunction

endpackage

// File: rtl/blake_round_ctrl_if.sv
// Job input and result handshake bundle of the BLAKE-512 round controller.
interface blake_round_ctrl_if;
  import blake512_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [H_W-1:0] h_in;
  logic [S_W-1:0] s_in;
  logic [T_W-1:0] t_in;
  logic           out_valid;
  logic           out_ready;
  logic [H_W-1:0] h_out;

  modport master (
    output in_valid, h_in, s_in, t_in, out_ready,
    input  in_ready, out_valid, h_out
  );

  modport slave (
    input  in_valid, h_in, s_in, t_in, out_ready,
    output in_ready, out_valid, h_out
  );
endinterface

// File: rtl/blake_finalize.sv
// Combinational BLAKE-512 finalisation: h'_i = h_i ^ s_(i mod 4) ^ v_i ^ v_(i+8).
module blake_finalize
  import blake512_pkg::*;
(
  input  logic [H_W-1:0] h,
  input  logic [S_W-1:0] s,
  input  logic [V_W-1:0] v,
  output logic [H_W-1:0] h_new
);

  always_comb begin
    h_new = '0;
    for (int unsigned i = 0; i < H_WORDS; i++) begin
      h_new[word_lsb(i, H_WORDS) +: WORD_W] = h_word(h, i) ^ s_word(s, i % S_WORDS) ^
                                              v_word(v, i) ^ v_word(v, i + H_WORDS);
    end
  end

endmodule

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 round sequencer: loads v from h/s/t, iterates the external G datapath for
// 4*NUM_ROUNDS steps, then finalises and returns h' over a valid/ready handshake.
module blake_round_ctrl
  import blake512_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  blake_round_ctrl_if.slave  bus,
  output logic [V_W-1:0]     v_out,
  output logic [5:0]         counter_idx,
  input  logic [V_W-1:0]     v_state_next,
  output logic               busy
);

  localparam logic [5:0] LAST_IDX = 6'(4 * NUM_ROUNDS - 1);

  state_e         state_q, state_d;
  logic [V_W-1:0] v_q, v_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [H_W-1:0] h_q, h_d;
  logic [S_W-1:0] s_q, s_d;
  logic [H_W-1:0] h_out_q, h_out_d;
  logic           out_valid_q, out_valid_d;
  logic [H_W-1:0] h_fin;

  blake_finalize u_finalize (
    .h     (h_q),
    .s     (s_q),
    .v     (v_q),
    .h_new (h_fin)
  );

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    h_d         = h_q;
    s_d         = s_q;
    h_out_d     = h_out_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          h_d     = bus.h_in;
          s_d     = bus.s_in;
          v_d     = init_state(bus.h_in, bus.s_in, bus.t_in);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        v_d = v_state_next;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StFin: begin
        h_out_d     = h_fin;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        // h_out stays frozen until the consumer takes it
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      v_q         <= '0;
      cnt_q       <= '0;
      h_q         <= '0;
      s_q         <= '0;
      h_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      h_q         <= h_d;
      s_q         <= s_d;
      h_out_q     <= h_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.h_out     = h_out_q;
  assign v_out         = v_q;
  assign counter_idx   = cnt_q;
  assign busy          = (state_q == StRun) || (state_q == StFin);

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed bench for blake_round_ctrl: loopback datapath on a 16-round instance and a real
// one-round G datapath on a 1-round instance, both checked through a result scoreboard.
module tb_blake_round_ctrl;
  import blake512_pkg::*;

  logic clk, rst;
  blake_round_ctrl_if bus16 ();
  blake_round_ctrl_if bus1 ();
  logic [1023:0] v_out16, v_next16, v_out1, v_next1, msg1;
  logic [5:0]    cidx16, cidx1;
  logic          busy16, busy1;
  logic [511:0]  sb16[$];
  logic [511:0]  sb1[$];
  logic [511:0]  mdl_h, mdl_hout;
  logic [255:0]  mdl_s;
  logic [1023:0] mdl_v;
  int n_vec = 0;
  int n_mis = 0;

  blake_round_ctrl #(.NUM_ROUNDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .v_out(v_out16), .counter_idx(cidx16),
    .v_state_next(v_next16), .busy(busy16)
  );
  blake_round_ctrl #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .v_out(v_out1), .counter_idx(cidx1),
    .v_state_next(v_next1), .busy(busy1)
  );
  blake_finalize u_model_fin (.h(mdl_h), .s(mdl_s), .v(mdl_v), .h_new(mdl_hout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] cst(input int i);
    case (i)
      0: return 64'h243F6A8885A308D3;   1: return 64'h13198A2E03707344;
      2: return 64'hA4093822299F31D0;   3: return 64'h082EFA98EC4E6C89;
      4: return 64'h452821E638D01377;   5: return 64'hBE5466CF34E90C6C;
      6: return 64'hC0AC29B7C97C50DD;   7: return 64'h3F84D5B5B5470917;
      8: return 64'h9216D5D98979FB1B;   9: return 64'hD1310BA698DFB5AC;
      10: return 64'h2FFD72DBD01ADFB7;  11: return 64'hB8E1AFED6A267E96;
      12: return 64'hBA7C9045F12C7F99;  13: return 64'h24A19947B3916CF7;
      14: return 64'h0801F2E2858EFC16;  default: return 64'h636920D871574E69;
    endcase
  endfunction

  function automatic logic [63:0] wd(input logic [1023:0] v, input int i);
    return v[1023-64*i -: 64];
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One BLAKE-512 G function; round 0 only, so the message permutation is the identity.
  function automatic logic [1023:0] g_apply(input logic [1023:0] vin, input logic [1023:0] m,
                                            input int gi);
    logic [1023:0] v;
    logic [63:0] a, b, c, d;
    int ia, ib, ic, id;
    v = vin;
    case (gi)
      0, 1, 2, 3: begin ia = gi; ib = gi + 4; ic = gi + 8; id = gi + 12; end
      4: begin ia = 0; ib = 5; ic = 10; id = 15; end
      5: begin ia = 1; ib = 6; ic = 11; id = 12; end
      6: begin ia = 2; ib = 7; ic = 8;  id = 13; end
      default: begin ia = 3; ib = 4; ic = 9; id = 14; end
    endcase
    a = wd(v, ia); b = wd(v, ib); c = wd(v, ic); d = wd(v, id);
    a = a + b + (wd(m, 2*gi) ^ cst(2*gi+1));
    d = rotr(d ^ a, 32); c = c + d; b = rotr(b ^ c, 25);
    a = a + b + (wd(m, 2*gi+1) ^ cst(2*gi));
    d = rotr(d ^ a, 16); c = c + d; b = rotr(b ^ c, 11);
    v[1023-64*ia -: 64] = a; v[1023-64*ib -: 64] = b;
    v[1023-64*ic -: 64] = c; v[1023-64*id -: 64] = d;
    return v;
  endfunction

  function automatic logic [1023:0] init_model(input logic [511:0] h, input logic [255:0] s,
                                               input logic [127:0] t);
    logic [1023:0] v;
    for (int i = 0; i < 8; i++) v[1023-64*i -: 64] = h[511-64*i -: 64];
    for (int i = 0; i < 4; i++) v[511-64*i -: 64] = s[255-64*i -: 64] ^ cst(i);
    v[255 -: 64] = t[127:64] ^ cst(4);
    v[191 -: 64] = t[127:64] ^ cst(5);
    v[127 -: 64] = t[63:0] ^ cst(6);
    v[63 -: 64]  = t[63:0] ^ cst(7);
    return v;
  endfunction

  // With v fed straight back, the h and (s ^ c) terms cancel pairwise.
  function automatic logic [511:0] exp_loop(input logic [255:0] s, input logic [127:0] t);
    return {cst(0), cst(1), cst(2), cst(3),
            s[255:192] ^ t[127:64] ^ cst(4), s[191:128] ^ t[127:64] ^ cst(5),
            s[127:64] ^ t[63:0] ^ cst(6), s[63:0] ^ t[63:0] ^ cst(7)};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  assign v_next16 = v_out16;

  always_comb begin
    v_next1 = v_out1;
    for (int k = 0; k < 2; k++) v_next1 = g_apply(v_next1, msg1, 2 * int'(cidx1[1:0]) + k);
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 512'(bus16.in_ready), 512'(1));
    check({tag, "_out_valid"}, 512'(bus16.out_valid), 512'(0));
    check({tag, "_busy"}, 512'(busy16), 512'(0));
    check({tag, "_cidx"}, 512'(cidx16), 512'(0));
    check({tag, "_h_out"}, bus16.h_out, 512'(0));
    check({tag, "_v_out_hi"}, v_out16[1023:512], 512'(0));
    check({tag, "_v_out_lo"}, v_out16[511:0], 512'(0));
  endtask

  initial begin
    int n;
    logic [511:0] iv, h, held;
    logic [255:0] s;
    logic [127:0] t;
    logic [1023:0] v_exp;

    iv = {64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B,
          64'hA54FF53A5F1D36F1, 64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
          64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.h_in = '0; bus16.s_in = '0; bus16.t_in = '0;
    bus16.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.h_in = '0; bus1.s_in = '0; bus1.t_in = '0;
    bus1.out_ready = 1'b1;
    msg1 = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Loopback job on the IV; consumer holds off afterwards
    s = '0; t = {64'h8, 64'h0};
    bus16.h_in = iv; bus16.s_in = s; bus16.t_in = t; bus16.in_valid = 1'b1;
    sb16.push_back(exp_loop(s, t));
    @(negedge clk);
    bus16.in_valid = 1'b0;
    v_exp = {iv, cst(0), cst(1), cst(2), cst(3), 64'h452821E638D0137F,
             64'hBE5466CF34E90C64, cst(6), cst(7)};
    for (int i = 0; i < 16; i++) check($sformatf("init_v%0d", i), 512'(wd(v_out16, i)),
                                       512'(wd(v_exp, i)));
    check("init_busy", 512'(busy16), 512'(1));
    check("init_in_ready", 512'(bus16.in_ready), 512'(0));
    check("cidx_0", 512'(cidx16), 512'(0));
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      check($sformatf("cidx_%0d", k), 512'(cidx16), 512'(k));
    end
    @(negedge clk);
    n = 64;
    check("fin_cidx_wrap", 512'(cidx16), 512'(0));
    check("fin_out_valid", 512'(bus16.out_valid), 512'(0));
    while (bus16.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lat16", 512'(n), 512'(65));
    held = bus16.h_out;
    for (int k = 0; k < 10; k++) begin
      check("bp_h_out", bus16.h_out, held);
      check("bp_in_ready", 512'(bus16.in_ready), 512'(0));
      check("bp_out_valid", 512'(bus16.out_valid), 512'(1));
      bus16.in_valid = (k % 3 == 0);
      bus16.h_in = rnd512();
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    check("hout16_iv", bus16.h_out, sb16.pop_front());
    @(negedge clk);
    check("ret_out_valid", 512'(bus16.out_valid), 512'(0));
    check("ret_in_ready", 512'(bus16.in_ready), 512'(1));
    check("ret_busy", 512'(busy16), 512'(0));

    // Reset in the middle of a run drops the job
    h = rnd512(); s = 256'(rnd512()); t = 128'(rnd512());
    bus16.h_in = h; bus16.s_in = s; bus16.t_in = t; bus16.in_valid = 1'b1;
    sb16.push_back(exp_loop(s, t));
    @(negedge clk);
    bus16.in_valid = 1'b0;
    n = 0;
    while (cidx16 != 6'd30 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_cidx30", 512'(cidx16), 512'(30));
    rst = 1'b1;
    sb16.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 512'(bus16.in_ready), 512'(1));

    h = rnd512(); s = 256'(rnd512()); t = 128'(rnd512());
    bus16.h_in = h; bus16.s_in = s; bus16.t_in = t; bus16.in_valid = 1'b1;
    sb16.push_back(exp_loop(s, t));
    @(negedge clk);
    bus16.in_valid = 1'b0;
    n = 0;
    while (bus16.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lat16_after_rst", 512'(n), 512'(65));
    check("hout16_rnd", bus16.h_out, sb16.pop_front());
    @(negedge clk);
    check("rnd_ret_out_valid", 512'(bus16.out_valid), 512'(0));

    // One-round instance with a real G datapath against a sequential software model
    for (int j = 0; j < 3; j++) begin
      h = rnd512(); s = 256'(rnd512()); t = 128'(rnd512());
      msg1 = {rnd512(), rnd512()};
      mdl_v = init_model(h, s, t);
      for (int gi = 0; gi < 8; gi++) mdl_v = g_apply(mdl_v, msg1, gi);
      mdl_h = h; mdl_s = s;
      #1;
      sb1.push_back(mdl_hout);
      bus1.h_in = h; bus1.s_in = s; bus1.t_in = t; bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      check($sformatf("r1_busy_%0d", j), 512'(busy1), 512'(1));
      n = 0;
      while (bus1.out_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("lat1_%0d", j), 512'(n), 512'(5));
      check($sformatf("hout1_%0d", j), bus1.h_out, sb1.pop_front());
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
